tl_arb_2x1: RTL and testbench

Two-master to one-slave TileLink-UL arbiter between the core's L1 ports (instruction and data) and the single memory slave `tl_mem`. It selects one master's A-channel transaction per grant. It holds the grant for every beat of a multi-beat Put. It widens the source ID with the master index, so D-channel responses route back by that index bit with no outstanding-transaction table.

---
 rtl/tl_pkg.sv | 41 ++++
 rtl/tl_arb_2x1_rr_arb2.sv | 50 +++++
 rtl/tl_arb_2x1.sv | 243 ++++++++++++++++++++++++
 tb/tb_tl_arb_2x1.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the L1-to-memory arbiter.
//   - A/D opcode constants used by the arbiter and its bench
//   - BEAT_LG: log2 of the beat size in bytes (16-byte beats)
//   - tl_beats(): number of A-channel beats for one request
package tl_pkg;

    localparam logic [2:0] A_PUTFULL = 3'd0;
    localparam logic [2:0] A_PUTPART = 3'd1;
    localparam logic [2:0] A_GET     = 3'd4;
    localparam logic [2:0] D_ACK     = 3'd0;
    localparam logic [2:0] D_ACKDATA = 3'd1;

    localparam int unsigned BEAT_LG     = 4;
    localparam int unsigned MAX_SIZE_LG = 12;
    localparam int unsigned BEATS_W     = 9;
    localparam int unsigned BEAT_CNT_W  = 8;

    // Burst tracking state; BURST means the grant is locked to the owner
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Only Puts carry data on A, so only they span more than one beat.
    // Sizes beyond the 4 KiB limit are illegal; they saturate at 256 beats
    // so the counter can never be loaded with a wrapped value.
    function automatic logic [BEATS_W-1:0] tl_beats(input logic [2:0] opcode,
                                                    input logic [7:0] size);
        logic [BEATS_W-1:0] beats;
        beats = BEATS_W'(1);
        if (((opcode == A_PUTFULL) || (opcode == A_PUTPART)) && (size > 8'(BEAT_LG))) begin
            if (size >= 8'(MAX_SIZE_LG)) begin
                beats = BEATS_W'(256);
            end else begin
                beats = BEATS_W'(1) << (size - 8'(BEAT_LG));
            end
        end
        return beats;
    endfunction

endpackage

// File: rtl/tl_arb_2x1_rr_arb2.sv
// Two-requester round-robin grant with burst lock.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req[1:0]        : request per master (already gated by reset)
//   lock, owner     : burst in progress and the master holding it
//   fire_last       : last beat of a transaction handshakes this cycle
//   grant_valid_c   : a master is granted (combinational)
//   grant_idx_c     : index of the granted master (combinational)
module rr_arb2
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       owner,
    input  logic       fire_last,
    output logic       grant_valid_c,
    output logic       grant_idx_c
);

    // Master preferred on the next tie
    logic prio;

    // Grant selection: owner while locked, otherwise single requester or prio
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = 1'b0;
        if (lock) begin
            grant_idx_c   = owner;
            grant_valid_c = req[owner];
        end else if (req == 2'b11) begin
            grant_idx_c   = prio;
            grant_valid_c = 1'b1;
        end else begin
            grant_idx_c   = req[1];
            grant_valid_c = |req;
        end
    end

    // The master that just completed loses the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (fire_last) begin
            prio <= ~grant_idx_c;
        end
    end

endmodule

// File: rtl/tl_arb_2x1.sv
// Two-master to one-slave TileLink-UL arbiter (L1 I/D ports to tl_mem).
// A channel: round-robin grant, held for every beat of a multi-beat Put;
// the slave-side source is {master index, master source}.
// D channel: stateless routing on the source MSB.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   m0_a_*, m1_a_*    : master A-channel requests (in), a_ready (out)
//   m0_d_*, m1_d_*    : master D-channel responses (out), d_ready (in)
//   s_a_*             : slave A-channel request (out), s_a_ready (in)
//   s_d_*             : slave D-channel response (in), s_d_ready (out)
module tl_arb_2x1
    import tl_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 128,
    parameter int unsigned SW = 3,
    parameter int unsigned ZW = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_a_valid,
    output logic            m0_a_ready,
    input  logic [2:0]      m0_a_opcode,
    input  logic [2:0]      m0_a_param,
    input  logic [ZW-1:0]   m0_a_size,
    input  logic [SW-1:0]   m0_a_source,
    input  logic [AW-1:0]   m0_a_address,
    input  logic [DW/8-1:0] m0_a_mask,
    input  logic [DW-1:0]   m0_a_data,
    input  logic            m0_a_corrupt,

    input  logic            m1_a_valid,
    output logic            m1_a_ready,
    input  logic [2:0]      m1_a_opcode,
    input  logic [2:0]      m1_a_param,
    input  logic [ZW-1:0]   m1_a_size,
    input  logic [SW-1:0]   m1_a_source,
    input  logic [AW-1:0]   m1_a_address,
    input  logic [DW/8-1:0] m1_a_mask,
    input  logic [DW-1:0]   m1_a_data,
    input  logic            m1_a_corrupt,

    output logic            m0_d_valid,
    input  logic            m0_d_ready,
    output logic [2:0]      m0_d_opcode,
    output logic [1:0]      m0_d_param,
    output logic [ZW-1:0]   m0_d_size,
    output logic [SW-1:0]   m0_d_source,
    output logic [2:0]      m0_d_sink,
    output logic            m0_d_denied,
    output logic [DW-1:0]   m0_d_data,
    output logic            m0_d_corrupt,

    output logic            m1_d_valid,
    input  logic            m1_d_ready,
    output logic [2:0]      m1_d_opcode,
    output logic [1:0]      m1_d_param,
    output logic [ZW-1:0]   m1_d_size,
    output logic [SW-1:0]   m1_d_source,
    output logic [2:0]      m1_d_sink,
    output logic            m1_d_denied,
    output logic [DW-1:0]   m1_d_data,
    output logic            m1_d_corrupt,

    output logic            s_a_valid,
    input  logic            s_a_ready,
    output logic [2:0]      s_a_opcode,
    output logic [2:0]      s_a_param,
    output logic [ZW-1:0]   s_a_size,
    output logic [SW:0]     s_a_source,
    output logic [AW-1:0]   s_a_address,
    output logic [DW/8-1:0] s_a_mask,
    output logic [DW-1:0]   s_a_data,
    output logic            s_a_corrupt,

    input  logic            s_d_valid,
    output logic            s_d_ready,
    input  logic [2:0]      s_d_opcode,
    input  logic [1:0]      s_d_param,
    input  logic [ZW-1:0]   s_d_size,
    input  logic [SW:0]     s_d_source,
    input  logic [2:0]      s_d_sink,
    input  logic            s_d_denied,
    input  logic [DW-1:0]   s_d_data,
    input  logic            s_d_corrupt
);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [1:0]              req;
    logic                    grant_valid;
    logic                    grant_idx;
    logic                    lock;
    logic                    owner;
    logic [BEAT_CNT_W-1:0]   beat;
    logic [BEATS_W-1:0]      beats;
    logic                    a_fire;
    logic                    fire_last;
    logic                    load_burst;
    logic                    dec_beat;
    logic                    d_sel;

    // Reset forces both requests low so nothing is presented to the slave
    assign req = rst ? 2'b00 : {m1_a_valid, m0_a_valid};

    rr_arb2 u_rr (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .lock          (lock),
        .owner         (owner),
        .fire_last     (fire_last),
        .grant_valid_c (grant_valid),
        .grant_idx_c   (grant_idx)
    );

    // A-channel forwarding from the granted master
    always_comb begin
        s_a_valid   = grant_valid;
        s_a_opcode  = m0_a_opcode;
        s_a_param   = m0_a_param;
        s_a_size    = m0_a_size;
        s_a_source  = {1'b0, m0_a_source};
        s_a_address = m0_a_address;
        s_a_mask    = m0_a_mask;
        s_a_data    = m0_a_data;
        s_a_corrupt = m0_a_corrupt;
        if (grant_idx) begin
            s_a_opcode  = m1_a_opcode;
            s_a_param   = m1_a_param;
            s_a_size    = m1_a_size;
            s_a_source  = {1'b1, m1_a_source};
            s_a_address = m1_a_address;
            s_a_mask    = m1_a_mask;
            s_a_data    = m1_a_data;
            s_a_corrupt = m1_a_corrupt;
        end
    end

    // Ready only to the master that holds the grant (or the burst)
    always_comb begin
        m0_a_ready = 1'b0;
        m1_a_ready = 1'b0;
        if (!rst && (grant_valid || lock)) begin
            m0_a_ready = s_a_ready & ~grant_idx;
            m1_a_ready = s_a_ready &  grant_idx;
        end
    end

    assign a_fire = s_a_valid & s_a_ready;
    assign beats  = tl_beats(s_a_opcode, 8'(s_a_size));

    // Burst state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst next-state: lock on a multi-beat first beat, unlock on the last
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (a_fire && (beats != BEATS_W'(1))) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (a_fire && (beat == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst outputs: lock flag and beat-counter controls
    always_comb begin
        lock       = 1'b0;
        fire_last  = 1'b0;
        load_burst = 1'b0;
        dec_beat   = 1'b0;
        case (state)
            ST_IDLE: begin
                fire_last  = a_fire && (beats == BEATS_W'(1));
                load_burst = a_fire && (beats != BEATS_W'(1));
            end
            ST_BURST: begin
                lock      = 1'b1;
                fire_last = a_fire && (beat == '0);
                dec_beat  = a_fire && (beat != '0);
            end
            default: begin
                lock = 1'b0;
            end
        endcase
    end

    // Owner and remaining-beat counter (beats left after this one, minus 1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 1'b0;
            beat  <= '0;
        end else if (load_burst) begin
            owner <= grant_idx;
            beat  <= BEAT_CNT_W'(beats - BEATS_W'(2));
        end else if (dec_beat) begin
            beat  <= beat - BEAT_CNT_W'(1);
        end
    end

    // D-channel routing on the source bit that the A path prepended
    assign d_sel = s_d_source[SW];

    always_comb begin
        m0_d_valid   = ~rst & s_d_valid & ~d_sel;
        m1_d_valid   = ~rst & s_d_valid &  d_sel;
        s_d_ready    = ~rst & (d_sel ? m1_d_ready : m0_d_ready);

        m0_d_opcode  = s_d_opcode;
        m0_d_param   = s_d_param;
        m0_d_size    = s_d_size;
        m0_d_source  = s_d_source[SW-1:0];
        m0_d_sink    = s_d_sink;
        m0_d_denied  = s_d_denied;
        m0_d_data    = s_d_data;
        m0_d_corrupt = s_d_corrupt;

        m1_d_opcode  = s_d_opcode;
        m1_d_param   = s_d_param;
        m1_d_size    = s_d_size;
        m1_d_source  = s_d_source[SW-1:0];
        m1_d_sink    = s_d_sink;
        m1_d_denied  = s_d_denied;
        m1_d_data    = s_d_data;
        m1_d_corrupt = s_d_corrupt;
    end

endmodule

// File: tb/tb_tl_arb_2x1.sv
// Directed self-checking bench for tl_arb_2x1.
module tb_tl_arb_2x1;
    import tl_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = 3;
    localparam int unsigned ZW = 8;

    logic            clk;
    logic            rst;

    logic            m0_a_valid, m0_a_ready, m0_a_corrupt;
    logic [2:0]      m0_a_opcode, m0_a_param;
    logic [ZW-1:0]   m0_a_size;
    logic [SW-1:0]   m0_a_source;
    logic [AW-1:0]   m0_a_address;
    logic [DW/8-1:0] m0_a_mask;
    logic [DW-1:0]   m0_a_data;

    logic            m1_a_valid, m1_a_ready, m1_a_corrupt;
    logic [2:0]      m1_a_opcode, m1_a_param;
    logic [ZW-1:0]   m1_a_size;
    logic [SW-1:0]   m1_a_source;
    logic [AW-1:0]   m1_a_address;
    logic [DW/8-1:0] m1_a_mask;
    logic [DW-1:0]   m1_a_data;

    logic            m0_d_valid, m0_d_ready, m0_d_denied, m0_d_corrupt;
    logic [2:0]      m0_d_opcode, m0_d_sink;
    logic [1:0]      m0_d_param;
    logic [ZW-1:0]   m0_d_size;
    logic [SW-1:0]   m0_d_source;
    logic [DW-1:0]   m0_d_data;

    logic            m1_d_valid, m1_d_ready, m1_d_denied, m1_d_corrupt;
    logic [2:0]      m1_d_opcode, m1_d_sink;
    logic [1:0]      m1_d_param;
    logic [ZW-1:0]   m1_d_size;
    logic [SW-1:0]   m1_d_source;
    logic [DW-1:0]   m1_d_data;

    logic            s_a_valid, s_a_ready, s_a_corrupt;
    logic [2:0]      s_a_opcode, s_a_param;
    logic [ZW-1:0]   s_a_size;
    logic [SW:0]     s_a_source;
    logic [AW-1:0]   s_a_address;
    logic [DW/8-1:0] s_a_mask;
    logic [DW-1:0]   s_a_data;

    logic            s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
    logic [2:0]      s_d_opcode, s_d_sink;
    logic [1:0]      s_d_param;
    logic [ZW-1:0]   s_d_size;
    logic [SW:0]     s_d_source;
    logic [DW-1:0]   s_d_data;

    int n_checks;
    int n_fail;

    tl_arb_2x1 #(.AW(AW), .DW(DW), .SW(SW), .ZW(ZW)) dut (
        .clk(clk), .rst(rst),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
        .m0_d_corrupt(m0_d_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
        .m1_d_corrupt(m1_d_corrupt),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sizes above 4 KiB are not legal on the A channel
    always @(posedge clk) begin
        if (!rst && s_a_valid && (s_a_opcode != A_GET)) begin
            assert (s_a_size <= 8'd12)
                else $error("FAIL size_legal: observed %0d required <= 12", s_a_size);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic v, input logic [2:0] op, input logic [7:0] sz,
                            input logic [2:0] src, input logic [31:0] addr);
        m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_source = src; m0_a_address = addr;
    endtask

    task automatic drive_m1(input logic v, input logic [2:0] op, input logic [7:0] sz,
                            input logic [2:0] src, input logic [31:0] addr);
        m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_source = src; m1_a_address = addr;
    endtask

    initial begin
        int fires;
        int k;
        logic [5:0] rdy_pat;
        logic [127:0] dbase;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive_m0(1'b1, A_GET, 8'd4, 3'd0, 32'h0);
        drive_m1(1'b0, A_GET, 8'd4, 3'd0, 32'h0);
        m0_a_param = '0; m0_a_mask = '1; m0_a_data = 128'h1111; m0_a_corrupt = 1'b0;
        m1_a_param = '0; m1_a_mask = '1; m1_a_data = 128'h2222; m1_a_corrupt = 1'b0;
        m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        s_a_ready = 1'b1;
        s_d_valid = 1'b1; s_d_opcode = D_ACK; s_d_param = '0; s_d_size = 8'd4;
        s_d_source = 4'b0000; s_d_sink = 3'd2; s_d_denied = 1'b0;
        s_d_data = '0; s_d_corrupt = 1'b0;

        // Reset holds every handshake low
        @(negedge clk);
        #1;
        check("rst_s_a_valid", s_a_valid, 1'b0);
        check("rst_m0_a_ready", m0_a_ready, 1'b0);
        check("rst_m0_d_valid", m0_d_valid, 1'b0);
        check("rst_s_d_ready", s_d_ready, 1'b0);
        check("rst_prio", dut.u_rr.prio, 1'b0);
        step();
        rst = 1'b0;
        s_d_valid = 1'b0;

        // Tie from reset: m0 first, then m1
        drive_m0(1'b1, A_GET, 8'd4, 3'd1, 32'h100);
        drive_m1(1'b1, A_GET, 8'd4, 3'd2, 32'h200);
        #1;
        check("tie1_src", s_a_source, 4'b0001);
        check("tie1_m1_ready", m1_a_ready, 1'b0);
        step();
        m0_a_valid = 1'b0;
        #1;
        check("tie1b_src", s_a_source, 4'b1010);
        check("tie1b_m1_ready", m1_a_ready, 1'b1);
        step();
        m1_a_valid = 1'b0;

        // m0 Get alone, then its D response
        drive_m0(1'b1, A_GET, 8'd4, 3'd3, 32'h8000_0000);
        #1;
        check("get_src", s_a_source, 4'b0011);
        check("get_addr", s_a_address, 32'h8000_0000);
        check("get_m0_ready", m0_a_ready, 1'b1);
        step();
        m0_a_valid = 1'b0;
        #1;
        check("get_lock", dut.lock, 1'b0);
        check("get_s_a_valid", s_a_valid, 1'b0);
        s_d_valid = 1'b1; s_d_source = 4'b0101; s_d_opcode = D_ACKDATA;
        s_d_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
        m0_d_ready = 1'b1; m1_d_ready = 1'b0;
        #1;
        check("d0_m0_valid", m0_d_valid, 1'b1);
        check("d0_m1_valid", m1_d_valid, 1'b0);
        check("d0_source", m0_d_source, 3'd5);
        check("d0_data", m0_d_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233);
        check("d0_opcode", m0_d_opcode, D_ACKDATA);
        check("d0_s_ready", s_d_ready, 1'b1);
        m0_d_ready = 1'b0;
        #1;
        check("d0_s_ready_low", s_d_ready, 1'b0);
        step();
        s_d_valid = 1'b0;

        // Second tie: m0 was served last, so m1 wins, then m0
        drive_m0(1'b1, A_GET, 8'd4, 3'd1, 32'h100);
        drive_m1(1'b1, A_GET, 8'd4, 3'd2, 32'h200);
        #1;
        check("tie2_src", s_a_source, 4'b1010);
        check("tie2_m0_ready", m0_a_ready, 1'b0);
        step();
        m1_a_valid = 1'b0;
        #1;
        check("tie2b_src", s_a_source, 4'b0001);
        step();
        m0_a_valid = 1'b0;

        // m1 4-beat PutFull; m0 arrives after beat 1 and must wait
        drive_m1(1'b1, A_PUTFULL, 8'd6, 3'd4, 32'h4000);
        #1;
        check("burst_m1_ready", m1_a_ready, 1'b1);
        check("burst_src", s_a_source, 4'b1100);
        step();
        drive_m0(1'b1, A_GET, 8'd4, 3'd1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("burst_m0_blocked", m0_a_ready, 1'b0);
            check("burst_lock", dut.lock, 1'b1);
            check("burst_hold_src", s_a_source, 4'b1100);
            step();
        end
        m1_a_valid = 1'b0;
        #1;
        check("post_burst_lock", dut.lock, 1'b0);
        check("post_burst_m0_ready", m0_a_ready, 1'b1);
        check("post_burst_src", s_a_source, 4'b0001);
        step();
        m0_a_valid = 1'b0;

        // 8-beat PutFull with s_a_ready toggling
        drive_m0(1'b1, A_PUTFULL, 8'd7, 3'd6, 32'h6000);
        fires = 0;
        for (int i = 0; i < 16; i++) begin
            s_a_ready = (i % 2 == 0);
            #1;
            if (i == 14) check("p8_lock_before_last", dut.lock, 1'b1);
            if (s_a_valid && s_a_ready) fires++;
            step();
        end
        m0_a_valid = 1'b0;
        s_a_ready = 1'b1;
        #1;
        check("p8_fires", 32'(fires), 32'd8);
        check("p8_lock_after", dut.lock, 1'b0);

        // AccessAckData to m1 with back-pressure; m0 A traffic alongside
        rdy_pat = 6'b111001;
        dbase = 128'hA5A5_0000_0000_0000_0000_0000_0000_0000;
        k = 0;
        drive_m0(1'b1, A_GET, 8'd4, 3'd5, 32'h500);
        for (int i = 0; i < 6; i++) begin
            s_d_valid  = 1'b1;
            s_d_source = 4'b1010;
            s_d_opcode = D_ACKDATA;
            s_d_data   = dbase + 128'(k);
            m1_d_ready = rdy_pat[i];
            m0_d_ready = 1'b1;
            #1;
            check("dd_s_ready", s_d_ready, rdy_pat[i]);
            check("dd_m1_valid", m1_d_valid, 1'b1);
            check("dd_m0_valid", m0_d_valid, 1'b0);
            check("dd_m1_source", m1_d_source, 3'd2);
            check("dd_m1_data", m1_d_data, dbase + 128'(k));
            check("dd_a_concurrent", m0_a_ready, 1'b1);
            if (s_d_ready) k++;
            step();
        end
        s_d_valid = 1'b0;
        m0_a_valid = 1'b0;
        #1;
        check("dd_delivered", 32'(k), 32'd4);

        // Reset after beat 2 of a 4-beat Put
        drive_m0(1'b1, A_PUTFULL, 8'd6, 3'd0, 32'h7000);
        step();
        step();
        #1;
        check("rb_lock_before", dut.lock, 1'b1);
        check("rb_prio_before", dut.u_rr.prio, 1'b1);
        rst = 1'b1;
        s_d_valid = 1'b1; s_d_source = 4'b0000; m0_d_ready = 1'b1;
        #1;
        check("rb_s_a_valid", s_a_valid, 1'b0);
        check("rb_m0_a_ready", m0_a_ready, 1'b0);
        check("rb_m1_a_ready", m1_a_ready, 1'b0);
        check("rb_m0_d_valid", m0_d_valid, 1'b0);
        check("rb_s_d_ready", s_d_ready, 1'b0);
        check("rb_lock", dut.lock, 1'b0);
        check("rb_prio", dut.u_rr.prio, 1'b0);
        step();
        rst = 1'b0;
        s_d_valid = 1'b0;
        m0_a_valid = 1'b0;
        drive_m1(1'b1, A_GET, 8'd4, 3'd3, 32'h300);
        #1;
        check("ra_s_a_valid", s_a_valid, 1'b1);
        check("ra_m1_ready", m1_a_ready, 1'b1);
        check("ra_src", s_a_source, 4'b1011);
        check("ra_lock", dut.lock, 1'b0);
        step();
        m1_a_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
